// File: rtl/ahb_rsp_router_if.sv
// Bundled grant-record and data-phase response signals for ahb_rsp_router.
// slave = router side, master = arbiter/AHB/requestor side.
interface ahb_rsp_router_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned LW    = 8,
  parameter int unsigned DEPTH = 4
);
  logic                       gnt_valid;
  logic [N-1:0]               gnt_owner;
  logic [LW-1:0]              gnt_len;
  logic                       gnt_ready;
  logic                       beat_valid;
  logic                       hready;
  logic                       hresp;
  logic [DW-1:0]              hrdata;
  logic [N-1:0]               rsp_valid;
  logic [DW-1:0]              rsp_data;
  logic                       rsp_err;
  logic                       rsp_last;
  logic                       orphan;
  logic [$clog2(DEPTH):0]     outstanding;

  modport slave (
    input  gnt_valid, gnt_owner, gnt_len, beat_valid, hready, hresp, hrdata,
    output gnt_ready, rsp_valid, rsp_data, rsp_err, rsp_last, orphan, outstanding
  );

  modport master (
    output gnt_valid, gnt_owner, gnt_len, beat_valid, hready, hresp, hrdata,
    input  gnt_ready, rsp_valid, rsp_data, rsp_err, rsp_last, orphan, outstanding
  );
endinterface

// File: rtl/ahb_rsp_router.sv
// Steers completed AHB data-phase beats to the burst owner recorded at grant
// time, using an in-order owner FIFO and a beat counter on the head entry.
module ahb_rsp_router #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned LW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ahb_rsp_router_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN_ERR} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   bcnt_q, bcnt_d;
  logic [CW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count, cnt_d;
  logic            orphan_q, orphan_d;
  logic [N-1:0]    rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_err_q, rsp_last_q;

  logic [N-1:0]    owner_mem [DEPTH];
  logic [LW-1:0]   len_mem   [DEPTH];

  logic            beat, full, push, pop, deliver, last, err_hold;
  logic [N-1:0]    head_owner;
  logic [LW-1:0]   head_len;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count      = wr_q - rd_q;
  assign beat       = bus.beat_valid && bus.hready;
  assign push       = bus.gnt_valid && !full;
  assign head_owner = owner_mem[rd_q[AW-1:0]];
  assign head_len   = len_mem[rd_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    orphan_d = orphan_q;
    pop      = 1'b0;
    deliver  = 1'b0;
    last     = 1'b0;
    err_hold = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) orphan_d = 1'b1;
      end
      ACTIVE: begin
        if (beat) begin
          deliver = 1'b1;
          if (bcnt_q == head_len) begin
            last   = 1'b1;
            pop    = 1'b1;
            bcnt_d = '0;
          end else begin
            bcnt_d   = bcnt_q + LW'(1);
            err_hold = bus.hresp;
          end
        end
      end
      DRAIN_ERR: begin
        pop    = 1'b1;
        bcnt_d = '0;
        if (beat) orphan_d = 1'b1;
      end
      default: ;
    endcase
    cnt_d = count + CW'(push) - CW'(pop);
    // An erred non-last beat parks in DRAIN_ERR; otherwise occupancy decides.
    if (err_hold)          state_d = DRAIN_ERR;
    else if (cnt_d != '0)  state_d = ACTIVE;
    else                   state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      owner_mem[wr_q[AW-1:0]] <= bus.gnt_owner;
      len_mem[wr_q[AW-1:0]]   <= bus.gnt_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      orphan_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      wr_q        <= wr_q + CW'(push);
      rd_q        <= rd_q + CW'(pop);
      orphan_q    <= orphan_d;
      rsp_valid_q <= deliver ? head_owner : '0;
      if (deliver) begin
        rsp_data_q <= bus.hrdata;
        rsp_err_q  <= bus.hresp;
        rsp_last_q <= last || bus.hresp;
      end
    end
  end

  assign bus.gnt_ready   = !full;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.orphan      = orphan_q;
  assign bus.outstanding = count;
endmodule

// File: tb/tb_ahb_rsp_router.sv
// Self-checking bench for ahb_rsp_router: directed scenarios followed by random
// traffic, compared each cycle against a queue-based model of burst ownership.
module tb_ahb_rsp_router;
  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_rsp_router_if #(.N(N), .DW(DW), .LW(LW), .DEPTH(DEPTH)) bus ();

  ahb_rsp_router #(.N(N), .DW(DW), .LW(LW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk)
    if (!rst && bus.gnt_valid)
      assert ($onehot(bus.gnt_owner)) else $error("gnt_owner not one-hot");

  typedef struct {
    logic [N-1:0] owner;
    int unsigned  len;
  } burst_t;

  burst_t        q[$];
  int unsigned   head_done;
  bit            terminated;
  bit            m_orphan;
  logic [N-1:0]  exp_v;
  logic [DW-1:0] exp_d;
  logic          exp_e, exp_l;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a burst owns beats until len+1 delivered; an error ends it early
  // and it leaves the queue one cycle later, during which beats are lost.
  task automatic model_edge();
    bit beat;
    bit accept;
    beat   = bus.beat_valid && bus.hready;
    accept = bus.gnt_valid && (q.size() < DEPTH);
    exp_v  = '0;
    if (rst) begin
      q.delete();
      head_done  = 0;
      terminated = 0;
      m_orphan   = 0;
      exp_d = '0; exp_e = 0; exp_l = 0;
      return;
    end
    if (terminated) begin
      void'(q.pop_front());
      terminated = 0;
      head_done  = 0;
      if (beat) m_orphan = 1;
    end else if (q.size() == 0) begin
      if (beat) m_orphan = 1;
    end else if (beat) begin
      exp_v = q[0].owner;
      exp_d = bus.hrdata;
      exp_e = bus.hresp;
      head_done++;
      if (head_done == q[0].len + 1) begin
        exp_l = 1;
        void'(q.pop_front());
        head_done = 0;
      end else if (bus.hresp) begin
        exp_l = 1;
        terminated = 1;
      end else begin
        exp_l = 0;
      end
    end
    if (accept) q.push_back('{owner: bus.gnt_owner, len: int'(bus.gnt_len)});
  endtask

  task automatic compare();
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    if (exp_v != '0) begin
      check("rsp_data", 64'(bus.rsp_data), 64'(exp_d));
      check("rsp_err",  64'(bus.rsp_err),  64'(exp_e));
      check("rsp_last", 64'(bus.rsp_last), 64'(exp_l));
    end
    check("orphan",      64'(bus.orphan),      64'(m_orphan));
    check("outstanding", 64'(bus.outstanding), 64'(q.size()));
    check("gnt_ready",   64'(bus.gnt_ready),   64'(q.size() < DEPTH));
  endtask

  task automatic step(input logic r, input logic gv, input logic [N-1:0] own,
                      input logic [LW-1:0] len, input logic bv, input logic hr,
                      input logic he, input logic [DW-1:0] d);
    rst            = r;
    bus.gnt_valid  = gv;
    bus.gnt_owner  = own;
    bus.gnt_len    = len;
    bus.beat_valid = bv;
    bus.hready     = hr;
    bus.hresp      = he;
    bus.hrdata     = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();            step(0, 0, '0, '0, 0, 0, 0, '0); endtask
  task automatic reset_cyc();       step(1, 0, '0, '0, 0, 0, 0, '0); endtask
  task automatic push(input logic [N-1:0] o, input logic [LW-1:0] l);
    step(0, 1, o, l, 0, 0, 0, '0);
  endtask
  task automatic beat(input logic [DW-1:0] d, input logic e);
    step(0, 0, '0, '0, 1, 1, e, d);
  endtask

  initial begin
    logic [N-1:0]  o;
    logic [LW-1:0] l;
    reset_cyc(); reset_cyc();

    // single beat
    push(4'b0010, 8'd0);
    beat(32'hA5A5_0001, 0);
    idle();

    // back-to-back bursts
    push(4'b0001, 8'd3);
    push(4'b1000, 8'd1);
    for (int i = 0; i < 6; i++) beat(32'h1000_0000 + 32'(i), 0);
    idle();

    // full FIFO
    for (int i = 0; i < 5; i++) push(4'b0001 << (i % 4), 8'd0);
    beat(32'hBEEF_0000, 0);
    idle();
    for (int i = 0; i < 3; i++) beat(32'hBEEF_0001 + 32'(i), 0);
    idle();

    // error mid-burst, then a beat during the drain
    push(4'b0100, 8'd3);
    beat(32'hE000_0001, 0);
    beat(32'hE000_0002, 1);
    beat(32'hE000_0003, 0);
    idle(); idle();

    // orphan beat coinciding with a push
    reset_cyc();
    step(0, 1, 4'b1000, 8'd0, 1, 1, 0, 32'h0BAD_0000);
    beat(32'h600D_0001, 0);
    idle();

    // reset mid-burst
    reset_cyc();
    push(4'b0010, 8'd3);
    beat(32'h7000_0001, 0);
    step(1, 0, '0, '0, 1, 1, 0, 32'h7000_0002);
    idle();
    beat(32'h7000_0003, 0);
    idle();

    // random traffic
    reset_cyc();
    for (int c = 0; c < 4000; c++) begin
      o = '0;
      o[$urandom_range(0, N-1)] = 1'b1;
      l = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 20)) : LW'($urandom_range(0, 3));
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0), o, l,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) == 0), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
